// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one registered memory request per load/store,
// store lane replication/byte enables, load lane select and sign/zero extension.
// BUSYWAIT stalls the pipeline from issue through ACCESS; FAULT pulses on bad or timed-out accesses.
module mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEMREAD_IN,
  input  logic        MEMWRITE_IN,
  input  logic [2:0]  FUNCT3_IN,
  input  logic [31:0] ADDR_IN,
  input  logic [31:0] STORE_DATA_IN,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WRITEDATA,
  output logic [3:0]  MEM_BYTEEN,
  output logic [31:0] LOAD_DATA,
  output logic        BUSYWAIT,
  output logic        FAULT
);

  // Counter only has to reach MAX_WAIT-1; a zero MAX_WAIT disables the timeout.
  localparam int            CW         = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST  = CW'(MAX_WAIT - 1);
  localparam bit            TIMEOUT_EN = (MAX_WAIT != 0);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t        state_q;
  logic          mem_read_q;
  logic          mem_write_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [3:0]    mem_byteen_q;
  logic [31:0]   load_data_q;
  logic          fault_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    f3_q;
  logic [1:0]    alo_q;

  logic          req_any;
  logic          req_one;
  logic          f3_legal;
  logic          addr_aligned;
  logic          req_ok;
  logic          req_bad;
  logic [3:0]    byteen_d;
  logic [31:0]   wdata_d;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [31:0]   ldata_d;

  // Classify the instruction currently in MEM: valid access, bad access, or not a memory op.
  always_comb begin
    req_any = MEMREAD_IN | MEMWRITE_IN;
    req_one = MEMREAD_IN ^ MEMWRITE_IN;
    if (MEMWRITE_IN) begin
      f3_legal = (FUNCT3_IN == F3_B) || (FUNCT3_IN == F3_H) || (FUNCT3_IN == F3_W);
    end else begin
      f3_legal = (FUNCT3_IN == F3_B) || (FUNCT3_IN == F3_H) || (FUNCT3_IN == F3_W) ||
                 (FUNCT3_IN == F3_BU) || (FUNCT3_IN == F3_HU);
    end
    // funct3[1:0] is the access size for every legal encoding.
    case (FUNCT3_IN[1:0])
      2'b01:   addr_aligned = ~ADDR_IN[0];
      2'b10:   addr_aligned = (ADDR_IN[1:0] == 2'b00);
      default: addr_aligned = 1'b1;
    endcase
    req_ok  = req_one & f3_legal & addr_aligned;
    req_bad = req_any & ~req_ok;
  end

  // Store lane formatting; loads always present all four enables.
  always_comb begin
    byteen_d = 4'b1111;
    wdata_d  = STORE_DATA_IN;
    if (MEMWRITE_IN) begin
      case (FUNCT3_IN[1:0])
        2'b00: begin
          byteen_d = 4'b0001 << ADDR_IN[1:0];
          wdata_d  = {4{STORE_DATA_IN[7:0]}};
        end
        2'b01: begin
          byteen_d = ADDR_IN[1] ? 4'b1100 : 4'b0011;
          wdata_d  = {2{STORE_DATA_IN[15:0]}};
        end
        default: begin
          byteen_d = 4'b1111;
          wdata_d  = STORE_DATA_IN;
        end
      endcase
    end
  end

  // Load lane select and extension, driven by the funct3/offset latched at issue.
  always_comb begin
    case (alo_q)
      2'd0:    lane_byte = MEM_READDATA[7:0];
      2'd1:    lane_byte = MEM_READDATA[15:8];
      2'd2:    lane_byte = MEM_READDATA[23:16];
      default: lane_byte = MEM_READDATA[31:24];
    endcase
    lane_half = alo_q[1] ? MEM_READDATA[31:16] : MEM_READDATA[15:0];
    case (f3_q)
      F3_B:    ldata_d = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    ldata_d = {{16{lane_half[15]}}, lane_half};
      F3_W:    ldata_d = MEM_READDATA;
      F3_BU:   ldata_d = {24'd0, lane_byte};
      F3_HU:   ldata_d = {16'd0, lane_half};
      default: ldata_d = 32'd0;
    endcase
  end

  // Request FSM; every output it drives is registered. DONE exists so the
  // instruction still sitting on the inputs is not issued a second time.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_byteen_q <= 4'd0;
      load_data_q  <= 32'd0;
      fault_q      <= 1'b0;
      cnt_q        <= '0;
      f3_q         <= 3'd0;
      alo_q        <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          fault_q <= 1'b0;
          if (req_ok) begin
            state_q      <= ST_ACCESS;
            f3_q         <= FUNCT3_IN;
            alo_q        <= ADDR_IN[1:0];
            mem_addr_q   <= {ADDR_IN[31:2], 2'b00};
            mem_wdata_q  <= wdata_d;
            mem_byteen_q <= byteen_d;
            mem_read_q   <= MEMREAD_IN;
            mem_write_q  <= MEMWRITE_IN;
            cnt_q        <= '0;
          end else if (req_bad) begin
            fault_q     <= 1'b1;
            load_data_q <= 32'd0;
          end
        end
        ST_ACCESS: begin
          if (!MEM_BUSYWAIT) begin
            state_q     <= ST_DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (mem_read_q) begin
              load_data_q <= ldata_d;
            end
          end else if (TIMEOUT_EN && (cnt_q == WAIT_LAST)) begin
            state_q     <= ST_DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            load_data_q <= 32'd0;
            fault_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          fault_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall from the issue cycle through ACCESS; DONE lets the pipeline advance.
  assign BUSYWAIT      = ~RESET & (((state_q == ST_IDLE) & req_ok) | (state_q == ST_ACCESS));
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDR      = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign MEM_BYTEEN    = mem_byteen_q;
  assign LOAD_DATA     = load_data_q;
  assign FAULT         = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed reference memory plus a latency-programmable
// responder; each instruction is held until BUSYWAIT drops, then the pipeline advances.
module tb_mem_access_unit;

  logic        CLK;
  logic        RESET;
  logic        MEMREAD_IN;
  logic        MEMWRITE_IN;
  logic [2:0]  FUNCT3_IN;
  logic [31:0] ADDR_IN;
  logic [31:0] STORE_DATA_IN;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WRITEDATA;
  logic [3:0]  MEM_BYTEEN;
  logic [31:0] LOAD_DATA;
  logic        BUSYWAIT;
  logic        FAULT;

  mem_access_unit #(.MAX_WAIT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .MEMREAD_IN(MEMREAD_IN), .MEMWRITE_IN(MEMWRITE_IN), .FUNCT3_IN(FUNCT3_IN),
    .ADDR_IN(ADDR_IN), .STORE_DATA_IN(STORE_DATA_IN),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_BYTEEN(MEM_BYTEEN),
    .LOAD_DATA(LOAD_DATA), .BUSYWAIT(BUSYWAIT), .FAULT(FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Memory seen by the DUT (word array) and the model's byte view of the same contents.
  logic [31:0] mem [0:255];
  logic [7:0]  ref_bytes [0:1023];
  int          lat = 0;
  int          req_age = 0;
  bit          stuck = 1'b0;
  int          comp = 0;

  assign MEM_READDATA = mem[MEM_ADDR[9:2]];
  assign MEM_BUSYWAIT = stuck | ((MEM_READ | MEM_WRITE) & (req_age < lat));

  always @(posedge CLK) begin
    if (((MEM_READ | MEM_WRITE) === 1'b1) && (MEM_BUSYWAIT === 1'b1)) req_age <= req_age + 1;
    else req_age <= 0;
  end

  // Results of the most recent do_op.
  int          cyc, bw, reqc;
  logic [31:0] ld_last, ld_next, cap_a, cap_wd;
  logic [3:0]  cap_be;
  logic        flt_last, flt_next;

  task automatic set_word(input int a, input logic [31:0] v);
    mem[a >> 2] = v;
    for (int i = 0; i < 4; i++) ref_bytes[(a & ~3) + i] = v[8*i +: 8];
  endtask

  function automatic bit ref_valid(input logic rd, input logic wr, input logic [2:0] f3, input int a);
    int size;
    if (rd == wr) return 1'b0;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    size = 1 << f3[1:0];
    return (a % size) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
    logic [31:0] v;
    case (f3)
      3'd0: begin v = {24'd0, ref_bytes[a]}; if (v >= 128) v = v - 256; end
      3'd1: begin v = {16'd0, ref_bytes[a+1], ref_bytes[a]}; if (v >= 32768) v = v - 65536; end
      3'd2: v = {ref_bytes[a+3], ref_bytes[a+2], ref_bytes[a+1], ref_bytes[a]};
      3'd4: v = {24'd0, ref_bytes[a]};
      3'd5: v = {16'd0, ref_bytes[a+1], ref_bytes[a]};
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input int a, input logic [31:0] d);
    int n;
    n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) ref_bytes[a + i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a & ~3;
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  task automatic idle(input int n);
    MEMREAD_IN = 1'b0; MEMWRITE_IN = 1'b0; FUNCT3_IN = 3'd0; ADDR_IN = 32'd0; STORE_DATA_IN = 32'd0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Present one instruction and hold it until the pipeline may advance (BUSYWAIT low at the edge).
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input bit scramble);
    bit adv;
    adv = 1'b0;
    MEMREAD_IN = rd; MEMWRITE_IN = wr; FUNCT3_IN = f3; ADDR_IN = a; STORE_DATA_IN = d;
    cyc = 0; bw = 0; reqc = 0; cap_a = 32'd0; cap_be = 4'd0; cap_wd = 32'd0;
    ld_last = 32'd0; flt_last = 1'b0;
    while (!adv && cyc < 40) begin
      #1;
      if (BUSYWAIT === 1'b1) bw++; else adv = 1'b1;
      if ((MEM_READ | MEM_WRITE) === 1'b1) begin
        if (reqc == 0) begin cap_a = MEM_ADDR; cap_be = MEM_BYTEEN; cap_wd = MEM_WRITEDATA; end
        reqc++;
        if (MEM_BUSYWAIT === 1'b0) begin
          comp++;
          if (MEM_WRITE === 1'b1)
            for (int i = 0; i < 4; i++)
              if (MEM_BYTEEN[i]) mem[MEM_ADDR[9:2]][8*i +: 8] = MEM_WRITEDATA[8*i +: 8];
        end
      end
      ld_last = LOAD_DATA; flt_last = FAULT;
      @(posedge CLK); #1;
      cyc++;
      if (scramble && !adv) begin
        FUNCT3_IN = 3'($urandom); ADDR_IN = $urandom; STORE_DATA_IN = $urandom;
      end
    end
    tests++;
    if (!adv) begin
      fails++;
      $display("FAIL op_advance: still stalled after %0d cycles, required to advance", cyc);
    end
    ld_next = LOAD_DATA; flt_next = FAULT;
  endtask

  task automatic test_reset();
    RESET = 1'b1; stuck = 1'b0; lat = 0;
    MEMREAD_IN = 1'b0; MEMWRITE_IN = 1'b0; FUNCT3_IN = 3'd0; ADDR_IN = 32'd0; STORE_DATA_IN = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    tests++;
    if ({MEM_READ, MEM_WRITE, FAULT, BUSYWAIT} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl: rd/wr/fault/bw=%b required 0000", {MEM_READ, MEM_WRITE, FAULT, BUSYWAIT});
    end
    tests++;
    if ({MEM_ADDR, MEM_WRITEDATA, LOAD_DATA, MEM_BYTEEN} !== 100'd0) begin
      fails++; $display("FAIL reset_data: addr=%h wd=%h ld=%h be=%b required all zero",
                        MEM_ADDR, MEM_WRITEDATA, LOAD_DATA, MEM_BYTEEN);
    end
    RESET = 1'b0;
    @(posedge CLK); #1;
    tests++;
    if ({BUSYWAIT, MEM_READ, MEM_WRITE} !== 3'b000) begin
      fails++; $display("FAIL reset_idle: bw/rd/wr=%b required 000", {BUSYWAIT, MEM_READ, MEM_WRITE});
    end
  endtask

  task automatic test_lw();
    int c0;
    set_word(32'h100, 32'hDEADBEEF);
    lat = 1; c0 = comp;
    do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 1'b0);
    tests++;
    if (bw != 3) begin fails++; $display("FAIL lw_busywait: %0d cycles high, required 3", bw); end
    tests++;
    if (ld_last !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data: got %h required deadbeef", ld_last); end
    tests++;
    if (reqc != bw - 1) begin fails++; $display("FAIL lw_read_window: MEM_READ high %0d cycles, required %0d", reqc, bw - 1); end
    tests++;
    if (cap_a !== 32'h100 || cap_be !== 4'b1111) begin
      fails++; $display("FAIL lw_addr: addr=%h be=%b required 00000100 1111", cap_a, cap_be);
    end
    tests++;
    if (comp - c0 != 1) begin fails++; $display("FAIL lw_requests: %0d completions, required 1", comp - c0); end
    idle(1);
  endtask

  task automatic test_load_fmt();
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] adr [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
    logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h00000000};
    set_word(32'h100, 32'h80FF0000);
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b1, 1'b0, f3s[i], adr[i], 32'd0, 1'b0);
      tests++;
      if (ld_last !== exp[i] || cyc != 3) begin
        fails++; $display("FAIL load_fmt[%0d]: data=%h cycles=%0d required %h in 3", i, ld_last, cyc, exp[i]);
      end
    end
    idle(1);
  endtask

  task automatic test_store_fmt();
    lat = 0;
    do_op(1'b0, 1'b1, 3'b000, 32'h201, 32'h12345678, 1'b0);
    ref_store(3'b000, 32'h201, 32'h12345678);
    tests++;
    if (cap_a !== 32'h200 || cap_be !== 4'b0010 || cap_wd !== 32'h78787878) begin
      fails++; $display("FAIL sb_fmt: addr=%h be=%b wd=%h required 00000200 0010 78787878", cap_a, cap_be, cap_wd);
    end
    tests++;
    if (mem[32'h200 >> 2] !== ref_word(32'h200)) begin
      fails++; $display("FAIL sb_mem: word=%h required %h", mem[32'h200 >> 2], ref_word(32'h200));
    end
    do_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h12345678, 1'b0);
    ref_store(3'b001, 32'h202, 32'h12345678);
    tests++;
    if (cap_be !== 4'b1100 || cap_wd !== 32'h56785678 || cyc != 3) begin
      fails++; $display("FAIL sh_fmt: be=%b wd=%h cycles=%0d required 1100 56785678 3", cap_be, cap_wd, cyc);
    end
    tests++;
    if (mem[32'h200 >> 2] !== ref_word(32'h200)) begin
      fails++; $display("FAIL sh_mem: word=%h required %h", mem[32'h200 >> 2], ref_word(32'h200));
    end
    idle(1);
  endtask

  task automatic test_invalid();
    logic        rds [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        wrs [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [5] = '{3'b010, 3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] adr [5] = '{32'h206, 32'h100, 32'h101, 32'h100, 32'h100};
    int c0;
    set_word(32'h300, 32'hA5A5A5A5);
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 1'b0);
      c0 = comp;
      do_op(rds[i], wrs[i], f3s[i], adr[i], 32'h12345678, 1'b0);
      tests++;
      if (cyc != 1 || bw != 0 || reqc != 0 || comp != c0) begin
        fails++; $display("FAIL invalid_nostall[%0d]: cycles=%0d bw=%0d req=%0d required 1 0 0", i, cyc, bw, reqc);
      end
      tests++;
      if (flt_next !== 1'b1 || ld_next !== 32'd0) begin
        fails++; $display("FAIL invalid_fault[%0d]: fault=%b ld=%h required 1 00000000", i, flt_next, ld_next);
      end
      idle(1);
      tests++;
      if (FAULT !== 1'b0 || MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin
        fails++; $display("FAIL invalid_pulse[%0d]: fault=%b rd=%b wr=%b required 0 0 0", i, FAULT, MEM_READ, MEM_WRITE);
      end
    end
  endtask

  task automatic test_timeout();
    int c0;
    lat = 0;
    do_op(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 1'b0);
    stuck = 1'b1; c0 = comp;
    do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 1'b0);
    stuck = 1'b0;
    tests++;
    if (reqc != 4 || bw != 5 || cyc != 6) begin
      fails++; $display("FAIL timeout_len: access=%0d bw=%0d cycles=%0d required 4 5 6", reqc, bw, cyc);
    end
    tests++;
    if (flt_last !== 1'b1 || ld_last !== 32'd0 || comp != c0) begin
      fails++; $display("FAIL timeout_fault: fault=%b ld=%h required 1 00000000", flt_last, ld_last);
    end
    tests++;
    if (flt_next !== 1'b0) begin fails++; $display("FAIL timeout_pulse: fault=%b after DONE required 0", flt_next); end
    do_op(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 1'b0);
    tests++;
    if (cyc != 3 || ld_last !== 32'hA5A5A5A5) begin
      fails++; $display("FAIL timeout_recover: cycles=%0d ld=%h required 3 a5a5a5a5", cyc, ld_last);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    stuck = 1'b1;
    MEMREAD_IN = 1'b1; MEMWRITE_IN = 1'b0; FUNCT3_IN = 3'b010; ADDR_IN = 32'h100; STORE_DATA_IN = 32'd0;
    repeat (2) begin @(posedge CLK); #1; end
    tests++;
    if (MEM_READ !== 1'b1 || BUSYWAIT !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre: rd=%b bw=%b required 1 1", MEM_READ, BUSYWAIT);
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    tests++;
    if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin
      fails++; $display("FAIL rstmid: rd=%b bw=%b required 0 0", MEM_READ, BUSYWAIT);
    end
    RESET = 1'b0; stuck = 1'b0;
    idle(1);
    tests++;
    if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0 || FAULT !== 1'b0) begin
      fails++; $display("FAIL rstmid_after: rd=%b bw=%b fault=%b required 0 0 0", MEM_READ, BUSYWAIT, FAULT);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [31:0] d;
    lat = 0; d = $urandom;
    c0 = comp;
    do_op(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 1'b0);
    tests++;
    if (cyc != 3 || comp - c0 != 1 || ld_last !== ref_load(3'b010, 32'h300)) begin
      fails++; $display("FAIL b2b_lw: cycles=%0d req=%0d ld=%h required 3 1 %h", cyc, comp - c0, ld_last, ref_load(3'b010, 32'h300));
    end
    c0 = comp;
    do_op(1'b0, 1'b1, 3'b010, 32'h304, d, 1'b0);
    ref_store(3'b010, 32'h304, d);
    tests++;
    if (cyc != 3 || comp - c0 != 1 || mem[32'h304 >> 2] !== ref_word(32'h304)) begin
      fails++; $display("FAIL b2b_sw: cycles=%0d req=%0d word=%h required 3 1 %h", cyc, comp - c0, mem[32'h304 >> 2], ref_word(32'h304));
    end
    c0 = comp;
    idle(3);
    tests++;
    if (comp != c0 || MEM_WRITE !== 1'b0 || MEM_READ !== 1'b0) begin
      fails++; $display("FAIL b2b_dup: extra requests=%0d wr=%b required 0 0", comp - c0, MEM_WRITE);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      int          kind, c0;
      logic        rd, wr, v;
      logic [2:0]  f3;
      logic [31:0] a, d, exp_ld;
      kind = $urandom_range(0, 9);
      rd = (kind == 1) || (kind >= 2 && kind < 6);
      wr = (kind == 1) || (kind >= 6);
      if (rd && !wr) f3 = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(3, 7));
      else f3 = 3'($urandom_range(0, 2));
      a = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      d = $urandom;
      lat = $urandom_range(0, 2);
      v = ref_valid(rd, wr, f3, a);
      exp_ld = (v && rd) ? ref_load(f3, a) : 32'd0;
      c0 = comp;
      do_op(rd, wr, f3, a, d, 1'b1);
      tests++;
      if (!(rd | wr)) begin
        if (cyc != 1 || flt_next !== 1'b0 || comp != c0) begin
          fails++; $display("FAIL rnd_nop[%0d]: cycles=%0d fault=%b required 1 0", n, cyc, flt_next);
        end
      end else if (!v) begin
        if (cyc != 1 || flt_next !== 1'b1 || ld_next !== 32'd0 || comp != c0) begin
          fails++; $display("FAIL rnd_bad[%0d]: f3=%b a=%h cycles=%0d fault=%b ld=%h required 1 1 0", n, f3, a, cyc, flt_next, ld_next);
        end
      end else if (rd) begin
        if (cyc != lat + 3 || comp - c0 != 1 || flt_last !== 1'b0 || ld_last !== exp_ld) begin
          fails++; $display("FAIL rnd_load[%0d]: f3=%b a=%h cycles=%0d ld=%h required %0d %h", n, f3, a, cyc, ld_last, lat + 3, exp_ld);
        end
      end else begin
        ref_store(f3, a, d);
        if (cyc != lat + 3 || comp - c0 != 1 || flt_last !== 1'b0 || mem[a >> 2] !== ref_word(a)) begin
          fails++; $display("FAIL rnd_store[%0d]: f3=%b a=%h cycles=%0d word=%h required %0d %h", n, f3, a, cyc, mem[a >> 2], lat + 3, ref_word(a));
        end
      end
    end
    idle(1);
  endtask

  initial begin
    RESET = 1'b1;
    MEMREAD_IN = 1'b0; MEMWRITE_IN = 1'b0; FUNCT3_IN = 3'd0; ADDR_IN = 32'd0; STORE_DATA_IN = 32'd0;
    for (int w = 0; w < 256; w++) set_word(w * 4, $urandom);
    test_reset();
    test_lw();
    test_load_fmt();
    test_store_fmt();
    test_invalid();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
